// File: rtl/sc_io_pkg.sv
// Shared definitions for the single-cycle computer memory-mapped input port:
// I/O window addresses, status bit positions and the address decode helper.
package sc_io_pkg;

    localparam logic [7:0] IO_SW_ONE = 8'h80;
    localparam logic [7:0] IO_STATUS = 8'h88;
    localparam logic [7:0] IO_SW_TWO = 8'h90;
    localparam logic [7:0] IO_KEY    = 8'h98;

    localparam int ST_ONE   = 0;
    localparam int ST_TWO   = 1;
    localparam int ST_KEY0  = 2;
    localparam int ST_KEY1  = 3;
    localparam int STATUS_W = 4;

    // Only addr[7] and addr[4:2] take part in the decode; fold them into a canonical byte address.
    function automatic logic [7:0] io_sel(input logic a7, input logic [2:0] a42);
        return {a7, 2'b00, a42, 2'b00};
    endfunction

endpackage

// File: rtl/sc_io_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one input group.
// SC_IO_IN_DEBOUNCE_EN undefined: the debouncer is bypassed and stable follows the synchronizer.
module sc_io_debounce #(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0,
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_next
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("sc_io_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            stable <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments keep s1 -> s2 a true two-stage shift.
            s1     <= raw;
            s2     <= s1;
            stable <= stable_next;
        end
    end

`ifdef SC_IO_IN_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // cnt saturates at CNT_MAX so a long-held input keeps re-accepting the same value.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand <= RESET_VAL;
            cnt  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: default assigned first so no latch is inferred.
        stable_next = stable;
        if ((s2 == cand) && (cnt == CNT_MAX)) begin
            stable_next = cand;
        end
    end
`else
    always_comb begin
        stable_next = s2;
    end
`endif

endmodule

// File: rtl/sc_io_in.sv
// Debounced memory-mapped input port in the addr[7]=1 I/O window, with a read-to-clear change status.
// SC_IO_IN_DEBOUNCE_EN selects the full debouncer; undefined gives a 3-edge synchronizer-only path.
module sc_io_in
    import sc_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [3:0]  sw_one,
    input  logic [3:0]  sw_two,
    input  logic [1:0]  key,
    output logic [31:0] dataout,
    output logic        changed
);

    logic [3:0]          one_stable, one_next;
    logic [3:0]          two_stable, two_next;
    logic [1:0]          key_stable, key_next;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] set_vec;
    logic [7:0]          sel;
    logic                clr;
    logic                unused_addr;

    assign unused_addr = ^{addr[31:8], addr[6:5], addr[1:0]};

    sc_io_debounce #(
        .WIDTH(4), .RESET_VAL(4'h0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_one (
        .clock(clock), .reset(reset), .raw(sw_one),
        .stable(one_stable), .stable_next(one_next)
    );

    sc_io_debounce #(
        .WIDTH(4), .RESET_VAL(4'h0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_two (
        .clock(clock), .reset(reset), .raw(sw_two),
        .stable(two_stable), .stable_next(two_next)
    );

    sc_io_debounce #(
        .WIDTH(2), .RESET_VAL(2'b11), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock(clock), .reset(reset), .raw(key),
        .stable(key_stable), .stable_next(key_next)
    );

    assign sel = io_sel(addr[7], addr[4:2]);
    assign clr = re && (sel == IO_STATUS);

    // Keys are active-low, so only the 1->0 (press) edge of the debounced level is recorded.
    always_comb begin
        set_vec           = '0;
        set_vec[ST_ONE]   = (one_next != one_stable);
        set_vec[ST_TWO]   = (two_next != two_stable);
        set_vec[ST_KEY0]  = key_stable[0] & ~key_next[0];
        set_vec[ST_KEY1]  = key_stable[1] & ~key_next[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status  <= '0;
            changed <= 1'b0;
        end else begin
            status  <= (clr ? '0 : status) | set_vec;
            changed <= |status;
        end
    end

    always_comb begin
        dataout = '0;
        case (sel)
            IO_SW_ONE: dataout = {28'b0, one_stable};
            IO_SW_TWO: dataout = {28'b0, two_stable};
            IO_STATUS: dataout = {28'b0, status};
            IO_KEY:    dataout = {30'b0, ~key_stable};
            default:   dataout = '0;
        endcase
    end

endmodule

// File: tb/tb_sc_io_in.sv
// Directed testbench for sc_io_in with DEBOUNCE_CYCLES=4; expected latency follows SC_IO_IN_DEBOUNCE_EN.
module tb_sc_io_in;
    import sc_io_pkg::*;

    localparam int D = 4;
`ifdef SC_IO_IN_DEBOUNCE_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = 3;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        re = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sw_one = 4'h0;
    logic [3:0]  sw_two = 4'h0;
    logic [1:0]  key = 2'b11;
    logic [31:0] dataout;
    logic        changed;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  exp_st = 4'h0;

    always #5 clock = ~clock;

    sc_io_in #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .addr(addr), .re(re),
        .sw_one(sw_one), .sw_two(sw_two), .key(key),
        .dataout(dataout), .changed(changed)
    );

    // Each step ends 1 time unit after a rising edge; inputs change and reads happen there.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b0;
        #1;
        d = dataout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_sw_one: got %h want %h", d, 32'h0); end
        rd({24'h0, IO_SW_TWO}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_sw_two: got %h want %h", d, 32'h0); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
        rd({24'h0, IO_KEY}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_key: got %h want %h", d, 32'h0); end
        vectors++;
        if (changed !== 1'b0) begin miscompares++; $display("FAIL reset_changed: got %b want 0", changed); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            rd({24'h0, IO_STATUS}, d); vectors++;
            if (d !== 32'h0 || changed !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_status cycle %0d: got %h/%b want 0/0", i, d, changed);
            end
        end
    endtask

    task automatic test_sw_one();
        logic [31:0] d;
        sw_one = 4'h5;
        step(LAT - 1);
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL sw_one_early: got %h want %h", d, 32'h0); end
        step(1);
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h5) begin miscompares++; $display("FAIL sw_one_accept: got %h want %h", d, 32'h5); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL sw_one_status: got %h want %h", d, 32'h1); end
        vectors++;
        if (changed !== 1'b0) begin miscompares++; $display("FAIL sw_one_changed_early: got %b want 0", changed); end
        step(1);
        vectors++;
        if (changed !== 1'b1) begin miscompares++; $display("FAIL sw_one_changed: got %b want 1", changed); end
        rd(32'h0000_0000, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL window_off: got %h want %h", d, 32'h0); end
        rd(32'h0000_0084, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_84: got %h want %h", d, 32'h0); end
        rd(32'hABCD_01E3, d); vectors++;
        if (d !== 32'h5) begin miscompares++; $display("FAIL alias_sw_one: got %h want %h", d, 32'h5); end
        exp_st = 4'b0001;
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        sw_two = 4'hA;
        step(3);
        sw_two = 4'h0;
`ifdef SC_IO_IN_DEBOUNCE_EN
        for (int i = 0; i < 12; i++) begin
            step(1);
            rd({24'h0, IO_SW_TWO}, d); vectors++;
            if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_sw_two cycle %0d: got %h want 0", i, d); end
            rd({24'h0, IO_STATUS}, d); vectors++;
            if (d !== {28'h0, exp_st}) begin
                miscompares++;
                $display("FAIL glitch_status cycle %0d: got %h want %h", i, d, {28'h0, exp_st});
            end
        end
`else
        step(12);
        rd({24'h0, IO_SW_TWO}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_sw_two: got %h want 0", d); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== {28'h0, exp_st | 4'b0010}) begin
            miscompares++;
            $display("FAIL glitch_status: got %h want %h", d, {28'h0, exp_st | 4'b0010});
        end
        addr = {24'h0, IO_STATUS};
        re   = 1'b1;
        step(1);
        re   = 1'b0;
        exp_st = 4'h0;
`endif
    endtask

    task automatic test_key();
        logic [31:0] d;
        key = 2'b01;
        step(LAT - 1);
        rd({24'h0, IO_KEY}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL key_early: got %h want %h", d, 32'h0); end
        step(1);
        rd({24'h0, IO_KEY}, d); vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL key_press: got %h want %h", d, 32'h2); end
        exp_st = exp_st | 4'b1000;
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== {28'h0, exp_st}) begin miscompares++; $display("FAIL key_status: got %h want %h", d, {28'h0, exp_st}); end
        step(1);
        vectors++;
        if (changed !== 1'b1) begin miscompares++; $display("FAIL key_changed: got %b want 1", changed); end
        key = 2'b11;
        step(LAT + 3);
        rd({24'h0, IO_KEY}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL key_release: got %h want %h", d, 32'h0); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== {28'h0, exp_st}) begin miscompares++; $display("FAIL release_status: got %h want %h", d, {28'h0, exp_st}); end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        addr = {24'h0, IO_STATUS};
        re   = 1'b1;
        #1;
        vectors++;
        if (dataout !== {28'h0, exp_st}) begin
            miscompares++;
            $display("FAIL clear_read: got %h want %h", dataout, {28'h0, exp_st});
        end
        step(1);
        re = 1'b0;
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL cleared_status: got %h want 0", d); end
        vectors++;
        if (changed !== 1'b1) begin miscompares++; $display("FAIL changed_lag: got %b want 1", changed); end
        step(1);
        vectors++;
        if (changed !== 1'b0) begin miscompares++; $display("FAIL changed_cleared: got %b want 0", changed); end

        // Clear lands on the same edge that sw_two becomes stable: the new bit survives.
        sw_two = 4'h3;
        step(LAT - 1);
        addr = {24'h0, IO_STATUS};
        re   = 1'b1;
        #1;
        vectors++;
        if (dataout !== 32'h0) begin miscompares++; $display("FAIL race_read: got %h want 0", dataout); end
        step(1);
        re = 1'b0;
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL race_status: got %h want %h", d, 32'h2); end
        rd({24'h0, IO_SW_TWO}, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL sw_two_accept: got %h want %h", d, 32'h3); end

        addr = 32'h0000_0008;
        re   = 1'b1;
        step(1);
        addr = 32'h0000_008C;
        step(1);
        re = 1'b0;
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL no_clear_other_addr: got %h want %h", d, 32'h2); end
        rd(32'h0000_008C, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_8c: got %h want 0", d); end
        exp_st = 4'b0010;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        sw_one = 4'h3;
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL rst_mid_sw_one: got %h want 0", d); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h0 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_status: got %h/%b want 0/0", d, changed);
        end
        step(LAT - 1);
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL rst_mid_early: got %h want 0", d); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL rst_mid_status_early: got %h want 0", d); end
        step(1);
        rd({24'h0, IO_SW_ONE}, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL rst_mid_accept: got %h want %h", d, 32'h3); end
        rd({24'h0, IO_SW_TWO}, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL rst_mid_sw_two: got %h want %h", d, 32'h3); end
        rd({24'h0, IO_STATUS}, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL rst_mid_status_set: got %h want %h", d, 32'h3); end
    endtask

    initial begin
        test_reset();
        test_sw_one();
        test_glitch();
        test_key();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sc_io_in.md
# sc_io_in

Debounced, memory-mapped input port for the single-cycle computer. It synchronizes and debounces the two 4-bit switch groups and two push keys, then presents them to the CPU load path in the `addr[7]=1` I/O window. It also keeps a read-to-clear status word that records which inputs have changed since the last status read. This is the input-side counterpart of the result display register in the data-memory I/O window.

## Interface
- `DEBOUNCE_CYCLES`, 500000 — number of consecutive stable cycles (10 ms at 50 MHz) required before an input change is accepted; minimum 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  32  CPU data address; only `addr[7]` and `addr[4:2]` are decoded.
- `re`  in  1  load strobe, qualifies read-to-clear.
- `sw_one`  in  4  raw switch group one; asynchronous.
- `sw_two`  in  4  raw switch group two; asynchronous.
- `key`  in  2  raw push keys, active-low; asynchronous.
- `dataout`  out  32  combinational read data.
- `changed`  out  1  OR of all status bits (level, registered).

## Operation
- Each input group passes through a two-flop synchronizer (`s1`, `s2`) and then a debouncer holding `cand`, `cnt` and `stable`.
- Debouncer behaviour on each edge:
  - If `s2 != cand`: load `cand <= s2` and set `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: load `stable <= cand`; `cnt` holds.
  - Otherwise: increment `cnt`.
- Read map (valid when `addr[7]=1`):
  - `addr[4:2]=000` (0x80): `{28'b0, one_stable}`.
  - `addr[4:2]=100` (0x90): `{28'b0, two_stable}`.
  - `addr[4:2]=010` (0x88): `{28'b0, status[3:0]}`.
  - `addr[4:2]=110` (0x98): `{30'b0, ~key_stable}`, so a pressed key reads as 1.
  - Any other address: 0.
- Status bit 0 sets when `one_stable` updates to a different value.
- Status bit 1 sets when `two_stable` updates to a different value.
- Status bits 2 and 3 set on a 1→0 transition of `key_stable[0]` and `key_stable[1]` respectively (press edge only).
- Read-to-clear: when `re & addr[7] & addr[4:2]==010`, all status bits clear at the end of that cycle. `dataout` returns the pre-clear value during the read cycle.
- Simultaneous set and clear on the same edge: set wins for that bit; other bits clear.
- Reset values:
  - Switch `s1`, `s2`, `cand`, `stable` = 0.
  - Key `s1`, `s2`, `cand`, `stable` = 2'b11 (released).
  - `cnt` = 0; status = 0; `changed` = 0.
- Reset asserted mid-debounce discards the pending candidate; reset never sets a status bit.
- If switches are nonzero after reset, they are accepted after normal debounce latency and bits 0/1 set.

## Timing
- An accepted change reaches `stable` on the (DEBOUNCE_CYCLES+3)th rising edge after the raw change is first sampled.
- The status bit sets on that same edge; `changed` follows one edge later.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s2` never reaches `stable`.
- `dataout` is combinational from registers, so the single-cycle CPU reads with zero added latency.
- `cnt` width = `$clog2(DEBOUNCE_CYCLES)`; `cnt` saturates and never wraps.

## Configuration
- `SC_IO_IN_DEBOUNCE_EN` defined: the full debouncer is built as specified above.
- `SC_IO_IN_DEBOUNCE_EN` undefined: `stable <= s2` directly, `cnt`/`cand` are removed, and latency is 3 edges. Intended for fast simulation; status and read-to-clear behaviour is unchanged.

## Structure
- Shared package `sc_io_pkg`:
  - Address constants `IO_SW_ONE=8'h80`, `IO_STATUS=8'h88`, `IO_SW_TWO=8'h90`, `IO_KEY=8'h98`.
  - Status bit indices `ST_ONE=0`, `ST_TWO=1`, `ST_KEY0=2`, `ST_KEY1=3`.
- Sub-module `sc_io_debounce` with parameters `WIDTH`, `RESET_VAL`, `DEBOUNCE_CYCLES`. It contains the synchronizer and debouncer and is instantiated three times (4, 4 and 2 bits wide).

## Test plan
- Run all scenarios with `DEBOUNCE_CYCLES=4`.
- Reset with all inputs at rest: read 0x80, 0x90 and 0x88 → 0; `changed`=0; no status bit sets in the following 20 cycles.
- `sw_one` 0→4'h5, held: read 0x80 = 5 from edge 7 onward; status = 4'b0001; `changed`=1 one edge later.
- `sw_two` toggled 4'hA for 3 cycles then back to 0: 0x90 stays 0 and status bit 1 never sets.
- `key[1]` driven low and held: 0x98 = 2'b10 after 7 edges; status bit 3 sets. Releasing the key sets no further bit.
- Status read-to-clear with `re`: `dataout` = 4'b1001 in the read cycle; status = 0 and `changed` = 0 afterward. Repeat the read on the same edge that `sw_two` becomes stable → status = 4'b0010.
- Assert `reset` at debounce `cnt`=2 with `sw_one`=4'h3 pending: after reset `stable`=0 and status=0; holding `sw_one` at 3 then accepts it 7 edges after reset deasserts.
